// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch stage and the memory stage.
// DM has fixed priority; each transaction runs IDLE -> BUSY -> DONE with a BUSY timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              bus_err,
    output logic              stall_if,
    output logic              stall_dm
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_dm;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_cnt;
    logic                r_drop;
    logic                r_err;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_grant_dm;
    logic                w_grant_if;
    logic                w_busy;
    logic                w_timeout;
    logic                w_drop_nxt;
    logic [DATA_W-1:0]   w_cap;

    assign w_busy     = (r_state == S_BUSY);
    assign w_grant_dm = (r_state == S_IDLE) & dm_req;
    assign w_grant_if = (r_state == S_IDLE) & ~dm_req & if_req & ~if_flush;
    assign w_timeout  = w_busy & ~mem_ready & ((r_cnt + 8'd1) == TMO);
    // A flush in the completing cycle must already suppress the fetch capture.
    assign w_drop_nxt = r_drop | (w_busy & ~r_owner_dm & if_flush);
    assign w_cap      = mem_ready ? mem_rdata : '0;

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~((r_state == S_DONE) & ~r_owner_dm & ~r_drop);
    assign stall_dm  = dm_req & ~((r_state == S_DONE) & r_owner_dm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        if_valid    = 1'b0;
        dm_valid    = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dm | w_grant_if) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_req = 1'b1;
                mem_we  = r_we;
                if (mem_ready | w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if_valid    = ~r_owner_dm & ~r_drop;
                dm_valid    = r_owner_dm;
                bus_err     = r_err & (r_owner_dm | ~r_drop);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_grant_dm) begin
                r_owner_dm <= 1'b1;
                r_we       <= dm_we;
                r_addr     <= dm_addr;
                r_wdata    <= dm_wdata;
            end else if (w_grant_if) begin
                r_owner_dm <= 1'b0;
                r_we       <= 1'b0;
                r_addr     <= if_addr;
            end

            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_busy & ~mem_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == S_DONE) begin
                r_drop <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                r_drop <= w_drop_nxt;
                if (w_busy) begin
                    r_err <= w_timeout;
                end
            end

            // Timeout forces the owner's data to zero; DM stores only keep old data on success.
            if (w_busy & (mem_ready | w_timeout)) begin
                if (~r_owner_dm & ~w_drop_nxt) begin
                    r_if_rdata <= w_cap;
                end else if (r_owner_dm & (~r_we | ~mem_ready)) begin
                    r_dm_rdata <= w_cap;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum BUSY cycles before abort (1..255).

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch-stage read request.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard outstanding fetch (taken branch/jump).
- dm_req  in  1  memory-stage request.
- dm_we  in  1  memory-stage write enable.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- mem_req  out  1  shared-port request.
- mem_we  out  1  shared-port write enable.
- mem_addr  out  ADDR_W  shared-port address.
- mem_wdata  out  DATA_W  shared-port write data.
- mem_rdata  in  DATA_W  shared-port read data.
- mem_ready  in  1  shared-port completion.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  fetch completion pulse.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  data completion pulse.
- bus_err  out  1  timeout pulse, coincident with the aborted valid.
- stall_if  out  1  fetch-stage stall request to hazard logic.
- stall_dm  out  1  memory-stage stall request to hazard logic.

Function
REQ-003 SHALL implement states IDLE, BUSY, DONE plus an owner register {IF, DM}.
REQ-004 In IDLE, dm_req SHALL win over if_req (fixed priority, older instruction first); the winner SHALL be latched into owner, with addr/we/wdata registered; next state BUSY.
REQ-005 In IDLE, a fetch grant SHALL be suppressed when if_flush=1 in the same cycle.
REQ-006 With no request, the block SHALL remain in IDLE.
REQ-007 In BUSY, mem_req SHALL be 1, and mem_addr/mem_we/mem_wdata SHALL be driven from the registered values; mem_we SHALL be 0 for IF ownership.
REQ-008 Outside BUSY, mem_req and mem_we SHALL be 0.
REQ-009 In BUSY, mem_ready=1 SHALL capture mem_rdata into if_rdata (owner IF) or into dm_rdata (owner DM, read only) and move to DONE.
REQ-010 A DM write SHALL leave dm_rdata unchanged.
REQ-011 A DONE state SHALL last exactly one cycle: owner's valid=1, then IDLE.
REQ-012 Minimum latency SHALL be: request sampled in IDLE at cycle N gives valid at N+2.
REQ-013 In BUSY, an 8-bit cycle counter SHALL start at 0 on entry and increment each cycle without mem_ready.
REQ-014 When the counter reaches TIMEOUT, the block SHALL go to DONE with bus_err=1, the owner's rdata forced to 0, and the owner's valid=1.
REQ-015 mem_ready arriving in the same cycle as the timeout SHALL take precedence (normal completion, no bus_err).
REQ-016 if_flush=1 while IF owns BUSY SHALL set a drop flag; the memory transaction SHALL still complete.
REQ-017 A set drop flag SHALL cause DONE to emit no if_valid and leave if_rdata unchanged; the flag SHALL clear on entering IDLE.
REQ-018 if_flush SHALL have no effect on DM transactions.
REQ-019 stall_if SHALL equal if_req AND NOT (DONE AND owner=IF AND NOT drop), combinationally.
REQ-020 stall_dm SHALL equal dm_req AND NOT (DONE AND owner=DM), combinationally.
REQ-021 A requester SHALL hold req/addr/data stable until its valid; a req still high in the cycle after valid SHALL be treated as a new request.
REQ-022 dm_req and if_req arriving together SHALL serve DM first, then IF in the IDLE following DM's DONE.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, owner IF, counter 0, drop 0, mem_req/mem_we/if_valid/dm_valid/bus_err 0, and if_rdata/dm_rdata/mem_addr/mem_wdata 0.
REQ-024 reset asserted mid-BUSY SHALL abandon the transaction with no valid pulse; the first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-025 Bench SHALL cover: if_req, if_addr=0x100, mem_ready on first BUSY cycle, mem_rdata=0x2402000A -> if_valid at N+2, if_rdata=0x2402000A, stall_if=1 for cycles N, N+1.
REQ-026 Bench SHALL cover: if_req and dm_req (read 0x200) together, ready after 2 cycles each -> DM served first, dm_valid before if_valid, mem_addr sequence 0x200 then the fetch address.
REQ-027 Bench SHALL cover: dm write 0x300←0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF during BUSY, dm_valid pulses, dm_rdata unchanged.
REQ-028 Bench SHALL cover: TIMEOUT=4, mem_ready never asserted -> DONE after 4 BUSY cycles, bus_err=1 and valid=1 for one cycle, rdata=0; separately, ready in the 4th cycle -> no bus_err.
REQ-029 Bench SHALL cover: if_flush during IF BUSY -> no if_valid, if_rdata retained, stall_if stays high, next fetch granted after IDLE.
REQ-030 Bench SHALL cover: reset asserted in BUSY -> mem_req=0 within the same cycle, no valid pulse, all outputs 0.
